// File: rtl/odd_sequence_monitor.sv
// rtl/odd_sequence_monitor.sv - receive-side checker and lock detector for the 4-bit odd up/down counter stream
// Optional ODD_MON_ERRCNT_EN: enables the 8-bit saturating step_err counter on err_count.
module odd_sequence_monitor #(
    parameter int unsigned LOCK_COUNT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_valid,
    input  logic [3:0] din,
    output logic       dir,
    output logic       locked,
    output logic       step_err,
    output logic       wrap,
    output logic [2:0] pos,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {EMPTY, ACQ, LOCKED} state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

    state_t     state, state_nx;
    logic [3:0] prev, prev_nx;
    logic [2:0] run, run_nx;
    logic       dir_nx, step_err_nx, wrap_nx;

    logic [3:0] prev_up, prev_dn, run_inc;
    logic       up_step, dn_step, legal, wrap_step;

    // Modulo-16 arithmetic makes 1111->0001 and 0001->1111 ordinary steps.
    assign prev_up   = prev + 4'd2;
    assign prev_dn   = prev - 4'd2;
    assign up_step   = (din == prev_up);
    assign dn_step   = (din == prev_dn);
    assign legal     = up_step || dn_step;
    assign wrap_step = (up_step && prev == 4'hF) || (dn_step && prev == 4'h1);
    assign run_inc   = {1'b0, run} + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= EMPTY;
            prev     <= 4'd0;
            run      <= 3'd0;
            dir      <= 1'b0;
            step_err <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state    <= state_nx;
            prev     <= prev_nx;
            run      <= run_nx;
            dir      <= dir_nx;
            step_err <= step_err_nx;
            wrap     <= wrap_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        prev_nx     = prev;
        run_nx      = run;
        dir_nx      = dir;
        step_err_nx = 1'b0;
        wrap_nx     = 1'b0;
        if (sample_valid) begin
            case (state)
                EMPTY: begin
                    if (din[0]) begin
                        prev_nx  = din;
                        run_nx   = 3'd0;
                        state_nx = ACQ;
                    end else begin
                        step_err_nx = 1'b1;
                    end
                end
                ACQ, LOCKED: begin
                    if (legal) begin
                        prev_nx = din;
                        dir_nx  = up_step;
                        wrap_nx = wrap_step;
                        if (state == ACQ) begin
                            run_nx = run_inc[2:0];
                            if (run_inc == LOCK_N)
                                state_nx = LOCKED;
                        end
                    end else if (din[0]) begin
                        step_err_nx = 1'b1;
                        prev_nx     = din;
                        run_nx      = 3'd0;
                        state_nx    = ACQ;
                    end else begin
                        step_err_nx = 1'b1;
                        state_nx    = EMPTY;
                    end
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    // pos always tracks the last accepted odd sample held in prev.
    assign pos    = prev[3:1];
    assign locked = (state == LOCKED);

`ifdef ODD_MON_ERRCNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_count <= 8'd0;
        else if (step_err_nx && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_odd_sequence_monitor.sv
// tb/tb_odd_sequence_monitor.sv - directed self-checking bench for odd_sequence_monitor
module tb_odd_sequence_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_valid = 1'b0;
    logic [3:0] din = 4'd0;
    logic       dir, locked, step_err, wrap;
    logic [2:0] pos;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    odd_sequence_monitor #(.LOCK_COUNT(2)) dut (
        .clk(clk),
        .reset(reset),
        .sample_valid(sample_valid),
        .din(din),
        .dir(dir),
        .locked(locked),
        .step_err(step_err),
        .wrap(wrap),
        .pos(pos),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_err(input int n);
`ifdef ODD_MON_ERRCNT_EN
        return (n > 255) ? 8'd255 : 8'(n);
`else
        return 8'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic samp(input logic [3:0] v);
        @(negedge clk);
        sample_valid = 1'b1;
        din = v;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        din = 4'd0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic l, input logic d, input logic [2:0] p,
                           input logic se, input logic w, input int ne);
        chk({tag, ".locked"}, 8'(locked), 8'(l));
        chk({tag, ".dir"}, 8'(dir), 8'(d));
        chk({tag, ".pos"}, 8'(pos), 8'(p));
        chk({tag, ".step_err"}, 8'(step_err), 8'(se));
        chk({tag, ".wrap"}, 8'(wrap), 8'(w));
        chk({tag, ".err_count"}, err_count, exp_err(ne));
    endtask

    initial begin
        #12;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        samp(4'h1); chk_all("acq1", 0, 0, 0, 0, 0, 0);
        samp(4'h3); chk_all("acq3", 0, 1, 1, 0, 0, 0);
        samp(4'h5); chk_all("lock5", 1, 1, 2, 0, 0, 0);

        for (int i = 0; i < 5; i++) begin
            idle();
            chk_all("gap", 1, 1, 2, 0, 0, 0);
        end
        samp(4'h7); chk_all("after_gap7", 1, 1, 3, 0, 0, 0);
        samp(4'h9);
        samp(4'hB);
        samp(4'hD); chk_all("upD", 1, 1, 6, 0, 0, 0);
        samp(4'hF); chk_all("upF", 1, 1, 7, 0, 0, 0);
        samp(4'h1); chk_all("wrap_up", 1, 1, 0, 0, 1, 0);
        idle();     chk_all("wrap_pulse_end", 1, 1, 0, 0, 0, 0);
        samp(4'hF); chk_all("wrap_dn", 1, 0, 7, 0, 1, 0);
        samp(4'hD);
        samp(4'hB);
        samp(4'h9);
        samp(4'h7); chk_all("dn7", 1, 0, 3, 0, 0, 0);

        samp(4'hB); chk_all("jump_odd", 0, 0, 5, 1, 0, 1);
        samp(4'hD); chk_all("relock1", 0, 1, 6, 0, 0, 1);
        samp(4'hF); chk_all("relock2", 1, 1, 7, 0, 0, 1);

        samp(4'h4); chk_all("even_locked", 0, 1, 7, 1, 0, 2);
        samp(4'h4); chk_all("even_empty", 0, 1, 7, 1, 0, 3);
        samp(4'h3); chk_all("acq_after_empty", 0, 1, 1, 0, 0, 3);
        samp(4'h3); chk_all("repeat", 0, 1, 1, 1, 0, 4);
        samp(4'h5); chk_all("run_cleared", 0, 1, 2, 0, 0, 4);
        samp(4'h7); chk_all("relock3", 1, 1, 3, 0, 0, 4);

        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        samp(4'h1);
        samp(4'h3); chk_all("post_reset_run1", 0, 1, 1, 0, 0, 0);
        samp(4'h5); chk_all("post_reset_lock", 1, 1, 2, 0, 0, 0);

        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 300; i++) begin
            samp(4'h0);
            if (i == 0 || i == 253 || i == 254 || i == 299)
                chk_all("sat", 0, 0, 0, 1, 0, i + 1);
        end
        idle();
        chk_all("sat_hold", 0, 0, 0, 0, 0, 300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/odd_sequence_monitor.md
# odd_sequence_monitor

Receive-side checker for the 4-bit odd up/down counter stream. Samples the counter value each qualified cycle, decodes the step direction and position, detects wrap-around, flags any value or step the counter cannot legally produce, and declares lock after a run of legal steps. Sits downstream of the counter, or on any link carrying its output, as the consumer and self-check of that sequence.

## Interface
- LOCK_COUNT, 2, consecutive legal steps required to enter LOCKED; legal range 1..7.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- sample_valid  in  1  din is sampled on this edge when 1
- din  in  4  counter value under check
- dir  out  1  direction of last legal step (1 = up, 0 = down)
- locked  out  1  high while in LOCKED
- step_err  out  1  one-cycle pulse: illegal value or illegal step
- wrap  out  1  one-cycle pulse: legal 1111->0001 (up) or 0001->1111 (down)
- pos  out  3  din[3:1] of last accepted odd sample (0..7)
- err_count  out  8  saturating count of step_err pulses

## Operation
- Internal: state {EMPTY, ACQ, LOCKED}, prev[3:0], run[2:0].
- Legal value: din[0] = 1. Legal step: din == prev + 2 (up) or din == prev - 2 (down), 4-bit modulo arithmetic; 1111+2 = 0001 and 0001-2 = 1111 fall out naturally. Repeat (din == prev) is illegal. Direction may reverse on any step; reversal is legal.
- Cycles with sample_valid = 0: no state, register or output change; pulses deassert.
- EMPTY, valid sample:
  - odd: prev <= din, pos <= din[3:1], run <= 0, go ACQ.
  - even: step_err pulse, stay EMPTY.
- ACQ, valid sample:
  - legal step: prev/pos update, dir <= step direction, wrap pulse if wrap step, run <= run+1; if run+1 == LOCK_COUNT go LOCKED.
  - illegal, din odd: step_err, prev/pos <= din, run <= 0, stay ACQ.
  - illegal, din even: step_err, go EMPTY, prev/pos unchanged.
- LOCKED, valid sample:
  - legal step: stay, update prev/pos/dir, wrap as above.
  - illegal, din odd: step_err, go ACQ, prev/pos <= din, run <= 0.
  - illegal, din even: step_err, go EMPTY.
- locked = (state == LOCKED).
- err_count increments on every step_err, saturates at 255.

## Timing
- All outputs registered; one-cycle latency: effects of a sample at edge N are visible after edge N.
- step_err and wrap are single-cycle pulses, never simultaneously high.
- reset low at any time: immediate asynchronous clear to EMPTY; dir = 0, locked = 0, step_err = 0, wrap = 0, pos = 0, err_count = 0, prev = 0, run = 0. Sampling resumes on the first rising edge after reset deasserts.
- Reset asserted mid-run discards lock; relock needs a fresh first sample plus LOCK_COUNT legal steps.

## Configuration
- ODD_MON_ERRCNT_EN defined: 8-bit saturating error counter implemented as above.
- Not defined: counter omitted; err_count port retained and driven constant 0. All other behaviour identical.

## Test plan
- Reset, then valid samples 0001,0011,0101 (LOCK_COUNT=2) -> locked rises after third sample, dir = 1, pos = 2, no step_err.
- Locked, up 1101,1111,0001 -> wrap pulses once on the 0001 sample, dir = 1, pos = 0; then 1111 -> wrap pulse, dir = 0.
- Locked at 0111, din 1011 -> step_err pulse, locked = 0, state ACQ, pos = 5, err_count +1; then 1101,1111 -> relock.
- EMPTY, din 0100 -> step_err, stays EMPTY; din repeat 0011,0011 in ACQ -> step_err, run cleared.
- sample_valid low for 5 cycles between 0101 and 0111 -> no change during gap, 0111 accepted as legal up step.
- 300 illegal samples with macro defined -> err_count holds 255; without macro -> err_count = 0 throughout; reset asserted mid-stream -> all outputs 0 asynchronously.
